// File: rtl/arith_unit_mc.sv
// Multi-cycle arithmetic unit: single-cycle ADD/SUB/MUL and a W-cycle restoring
// divider returning quotient and remainder, with a start/busy/done handshake.
module arith_unit_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [1:0]            ALU_FUNC,
    input  logic                  Signed_Mode,
    input  logic                  Arith_Enable,
    output logic                  Busy,
    output logic [OUT_WIDTH-1:0]  Arith_OUT,
    output logic                  Carry_OUT,
    output logic                  Ovf_OUT,
    output logic                  Div_Zero,
    output logic                  Arith_Flag
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] FUNC_ADD = 2'b00;
    localparam logic [1:0] FUNC_SUB = 2'b01;
    localparam logic [1:0] FUNC_MUL = 2'b10;
    localparam logic [1:0] FUNC_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DIV_FIX = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [OUT_WIDTH-1:0] out_reg, res_next;
    logic                 carry_reg, carry_next;
    logic                 ovf_reg, ovf_next;
    logic                 dz_reg, dz_next;
    logic                 flag_reg;

    logic [W-1:0]  rem_reg, quo_reg, dvs_reg;
    logic [CW-1:0] cnt_reg;
    logic          q_neg_reg, r_neg_reg, ovf_div_reg;

    // Operands widened by one bit so sum/difference are exact in either mode.
    logic [W:0]       a_ext, b_ext, sum_ext, diff_ext;
    logic [2*W-1:0]   mul_a, mul_b, prod;
    logic [W-1:0]     a_mag, b_mag;
    logic             a_neg, b_neg;
    logic             div_start;
    logic [W:0]       shifted, trial;
    logic [W-1:0]     quo_fix, rem_fix;

    always_comb begin
        a_neg    = Signed_Mode & A[W-1];
        b_neg    = Signed_Mode & B[W-1];
        a_ext    = {a_neg, A};
        b_ext    = {b_neg, B};
        sum_ext  = a_ext + b_ext;
        diff_ext = a_ext - b_ext;
        mul_a    = {{W{a_neg}}, A};
        mul_b    = {{W{b_neg}}, B};
        prod     = mul_a * mul_b;
        a_mag    = a_neg ? -A : A;
        b_mag    = b_neg ? -B : B;
        div_start = (state_reg == IDLE) && Arith_Enable &&
                    (ALU_FUNC == FUNC_DIV) && (B != '0);
    end

    always_comb begin
        res_next   = '0;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
        dz_next    = 1'b0;
        case (ALU_FUNC)
            FUNC_ADD: begin
                res_next   = {{(W-1){Signed_Mode & sum_ext[W]}}, sum_ext};
                // Recover the carry into bit W from the extended sum.
                carry_next = sum_ext[W] ^ a_ext[W] ^ b_ext[W];
                ovf_next   = Signed_Mode & (A[W-1] == B[W-1]) & (sum_ext[W-1] != A[W-1]);
            end
            FUNC_SUB: begin
                res_next   = {{(W-1){Signed_Mode & diff_ext[W]}}, diff_ext};
                carry_next = (A < B);
                ovf_next   = Signed_Mode & (A[W-1] != B[W-1]) & (diff_ext[W-1] != A[W-1]);
            end
            FUNC_MUL: begin
                res_next = prod;
            end
            default: begin
                res_next = {A, {W{1'b1}}};
                dz_next  = 1'b1;
            end
        endcase
    end

    always_comb begin
        shifted = {rem_reg, quo_reg[W-1]};
        trial   = shifted - {1'b0, dvs_reg};
        quo_fix = q_neg_reg ? -quo_reg : quo_reg;
        rem_fix = r_neg_reg ? -rem_reg : rem_reg;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (div_start) state_next = DIV_RUN;
            DIV_RUN: if (cnt_reg == CW'(W - 1)) state_next = DIV_FIX;
            DIV_FIX: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_reg     <= '0;
            carry_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
            dz_reg      <= 1'b0;
            flag_reg    <= 1'b0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            cnt_reg     <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            ovf_div_reg <= 1'b0;
        end else begin
            flag_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (div_start) begin
                        rem_reg     <= '0;
                        quo_reg     <= a_mag;
                        dvs_reg     <= b_mag;
                        cnt_reg     <= '0;
                        q_neg_reg   <= a_neg ^ b_neg;
                        r_neg_reg   <= a_neg;
                        // Only -2^(W-1) / -1 overflows; the quotient wraps naturally.
                        ovf_div_reg <= Signed_Mode && (A == {1'b1, {(W-1){1'b0}}}) &&
                                       (B == {W{1'b1}});
                    end else if (Arith_Enable) begin
                        out_reg   <= res_next;
                        carry_reg <= carry_next;
                        ovf_reg   <= ovf_next;
                        dz_reg    <= dz_next;
                        flag_reg  <= 1'b1;
                    end
                end
                DIV_RUN: begin
                    if (!trial[W]) begin
                        rem_reg <= trial[W-1:0];
                        quo_reg <= {quo_reg[W-2:0], 1'b1};
                    end else begin
                        rem_reg <= shifted[W-1:0];
                        quo_reg <= {quo_reg[W-2:0], 1'b0};
                    end
                    cnt_reg <= cnt_reg + 1'b1;
                end
                DIV_FIX: begin
                    out_reg   <= {rem_fix, quo_fix};
                    carry_reg <= 1'b0;
                    ovf_reg   <= ovf_div_reg;
                    dz_reg    <= 1'b0;
                    flag_reg  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Busy       = (state_reg != IDLE);
    assign Arith_OUT  = out_reg;
    assign Carry_OUT  = carry_reg;
    assign Ovf_OUT    = ovf_reg;
    assign Div_Zero   = dz_reg;
    assign Arith_Flag = flag_reg;

endmodule

// File: tb/tb_arith_unit_mc.sv
// Scoreboard bench for arith_unit_mc: stimulus pushes expected results, a
// monitor pops and compares on every Arith_Flag pulse.
module tb_arith_unit_mc;

    localparam int W = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [1:0]    ALU_FUNC = 2'b00;
    logic          Signed_Mode = 1'b0;
    logic          Arith_Enable = 1'b0;
    logic          Busy;
    logic [2*W-1:0] Arith_OUT;
    logic          Carry_OUT;
    logic          Ovf_OUT;
    logic          Div_Zero;
    logic          Arith_Flag;

    arith_unit_mc #(.DATA_WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUNC(ALU_FUNC),
        .Signed_Mode(Signed_Mode), .Arith_Enable(Arith_Enable), .Busy(Busy),
        .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Ovf_OUT(Ovf_OUT),
        .Div_Zero(Div_Zero), .Arith_Flag(Arith_Flag)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] out;
        logic           c;
        logic           o;
        logic           dz;
        int             at;
        string          name;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (!RST && Arith_Flag === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_flag: got Arith_Flag=1 at cycle %0d expected no result", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, ".out"},     64'(Arith_OUT), 64'(e.out));
                    check({e.name, ".carry"},   64'(Carry_OUT), 64'(e.c));
                    check({e.name, ".ovf"},     64'(Ovf_OUT),   64'(e.o));
                    check({e.name, ".divzero"}, 64'(Div_Zero),  64'(e.dz));
                    check({e.name, ".latency"}, 64'(cyc),       64'(e.at));
                    $display("result %-10s out=%h c=%b o=%b dz=%b cycle=%0d",
                             e.name, Arith_OUT, Carry_OUT, Ovf_OUT, Div_Zero, cyc);
                end
            end
        end
    end

    // Drive one start at the next falling edge and record its expected result.
    task automatic issue(input string name, input logic [1:0] f, input logic sm,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] out, input logic c, input logic o,
                         input logic dz, input int lat);
        exp_t e;
        @(negedge CLK);
        ALU_FUNC = f; Signed_Mode = sm; A = a; B = b; Arith_Enable = 1'b1;
        e.out = out; e.c = c; e.o = o; e.dz = dz; e.at = cyc + lat; e.name = name;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            Arith_Enable = 1'b0;
        end
    endtask

    // Divide with a Busy-cycle count and an ignored start pulse mid-run.
    task automatic div_op(input string name, input logic sm, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] out, input logic o);
        int busy_cnt = 0;
        issue(name, 2'b11, sm, a, b, out, 1'b0, o, 1'b0, W + 2);
        for (int i = 0; i < W + 6; i++) begin
            @(negedge CLK);
            if (Busy === 1'b1) busy_cnt++;
            Arith_Enable = 1'b0;
            if (i == 4) begin
                ALU_FUNC = 2'b00; A = 16'h0001; B = 16'h0001; Arith_Enable = 1'b1;
            end
        end
        check({name, ".busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
    endtask

    initial begin
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset.out",   64'(Arith_OUT),  64'h0);
        check("reset.flags", 64'({Busy, Carry_OUT, Ovf_OUT, Div_Zero, Arith_Flag}), 64'h0);
        RST = 1'b0;

        issue("add_u", 2'b00, 1'b0, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b1, 1'b0, 1'b0, 1);
        idle(2);
        issue("add_s", 2'b00, 1'b1, 16'h7FFF, 16'h0001, 32'h0000_8000, 1'b0, 1'b1, 1'b0, 1);
        idle(2);
        issue("sub_u", 2'b01, 1'b0, 16'h0003, 16'h0005, 32'h0001_FFFE, 1'b1, 1'b0, 1'b0, 1);
        idle(2);
        issue("sub_s", 2'b01, 1'b1, 16'h8000, 16'h0001, 32'hFFFF_7FFF, 1'b0, 1'b1, 1'b0, 1);
        idle(2);
        issue("mul_s", 2'b10, 1'b1, 16'hFFFD, 16'h0007, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0, 1);
        issue("mul_u", 2'b10, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 1'b0, 1'b0, 1);
        idle(2);

        div_op("div_s_m7_2", 1'b1, 16'hFFF9, 16'h0002, 32'hFFFF_FFFD, 1'b0);
        idle(2);
        issue("div_zero", 2'b11, 1'b0, 16'h0064, 16'h0000, 32'h0064_FFFF, 1'b0, 1'b0, 1'b1, 1);
        idle(2);
        issue("add_clr", 2'b00, 1'b0, 16'h0001, 16'h0002, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1);
        idle(2);
        div_op("div_s_min", 1'b1, 16'h8000, 16'hFFFF, 32'h0000_8000, 1'b1);
        idle(2);
        div_op("div_u_100_7", 1'b0, 16'h0064, 16'h0007, 32'h0002_000E, 1'b0);
        idle(2);
        div_op("div_s_7_m2", 1'b1, 16'h0007, 16'hFFFE, 32'h0001_FFFD, 1'b0);
        idle(2);

        // Abort a divide with reset: no result may appear afterwards.
        @(negedge CLK);
        ALU_FUNC = 2'b11; Signed_Mode = 1'b0; A = 16'h1234; B = 16'h0003; Arith_Enable = 1'b1;
        @(negedge CLK);
        Arith_Enable = 1'b0;
        repeat (4) @(negedge CLK);
        check("abort.busy_before", 64'(Busy), 64'h1);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check("abort.out",   64'(Arith_OUT), 64'h0);
        check("abort.flags", 64'({Busy, Carry_OUT, Ovf_OUT, Div_Zero, Arith_Flag}), 64'h0);
        repeat (W + 6) @(negedge CLK);
        check("abort.busy_after", 64'(Busy), 64'h0);
        check("abort.out_hold",   64'(Arith_OUT), 64'h0);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge CLK);
        check("scoreboard.drained", 64'(sb.size()), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/arith_unit_mc.md
Name: arith_unit_mc

Overview:
Parametrised, multi-cycle successor of the team's registered arithmetic unit. It supports ADD, SUB, MUL and DIV with a per-operation signed/unsigned mode, a start/busy/done handshake, full-precision results and status flags. Add, sub and multiply complete in one cycle. Divide is an iterative restoring divider that returns both quotient and remainder. The block sits in the ALU datapath beside the logic, compare and shift units; the ALU top muxes its outputs.

Parameters:
DATA_WIDTH, 16, operand width W (must be ≥ 4).
OUT_WIDTH, 2*DATA_WIDTH, result width (derived; do not override).

Ports:
CLK  input  1  clock; all logic is on the rising edge.
RST  input  1  reset, synchronous, active-high.
A  input  W  operand A.
B  input  W  operand B.
ALU_FUNC  input  2  operation select: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
Signed_Mode  input  1  1 = operands are two's complement; 0 = unsigned.
Arith_Enable  input  1  start strobe; sampled only when Busy=0.
Busy  output  1  high while a divide is in progress.
Arith_OUT  output  2W  result register.
Carry_OUT  output  1  ADD carry out / SUB borrow.
Ovf_OUT  output  1  signed overflow flag.
Div_Zero  output  1  divide-by-zero flag.
Arith_Flag  output  1  one-cycle pulse: the outputs hold a new result.

Behaviour:
- Reset: RST=1 at a clock edge forces state IDLE. Busy, Arith_OUT, Carry_OUT, Ovf_OUT, Div_Zero and Arith_Flag all go to 0.
- Reset mid-divide aborts the operation; no Arith_Flag is produced.
- RST has priority over Arith_Enable.
- States: IDLE, DIV_RUN, DIV_FIX.
- IDLE, Arith_Enable=1, ALU_FUNC != 11: the result registers at that edge. Arith_Flag pulses high for the following cycle, so latency is 1. The state stays IDLE, so back-to-back starts on every cycle are legal.
- ADD:
  - Arith_OUT = exact (W+1)-bit sum, sign-extended (Signed_Mode=1) or zero-extended (Signed_Mode=0) to 2W.
  - Carry_OUT = unsigned carry out of bit W-1.
  - Ovf_OUT = signed overflow of the W-bit sum when Signed_Mode=1, else 0.
- SUB:
  - Arith_OUT = exact (W+1)-bit difference A-B, extended to 2W as for ADD.
  - Carry_OUT = borrow, i.e. unsigned A < B.
  - Ovf_OUT = signed overflow of the W-bit difference when Signed_Mode=1, else 0.
- MUL:
  - Arith_OUT = full 2W product, signed or unsigned per Signed_Mode.
  - Carry_OUT=0, Ovf_OUT=0.
- DIV, B=0:
  - No iteration is run; latency 1.
  - Arith_OUT[W-1:0] = all ones.
  - Arith_OUT[2W-1:W] = A.
  - Div_Zero=1, Carry_OUT=0, Ovf_OUT=0.
- DIV, B≠0: on start, latch magnitudes and operand signs. Set Busy=1 and enter DIV_RUN.
  - DIV_RUN: one quotient bit per cycle for W cycles, under an iteration counter.
  - DIV_FIX: apply the sign corrections.
    - Quotient is truncated toward zero.
    - Remainder takes the sign of the dividend.
  - Return to IDLE with Busy=0 and Arith_Flag=1.
  - Arith_OUT[W-1:0] = quotient; Arith_OUT[2W-1:W] = remainder.
  - Start to Arith_Flag latency is W+2 cycles.
- Signed DIV of -2^(W-1) by -1:
  - quotient = -2^(W-1) (wraps), remainder = 0, Ovf_OUT=1.
- Flags from an operation stay valid until the next result. Div_Zero and Ovf_OUT clear on any later result that does not set them.
- Arith_Enable while Busy=1 is ignored; there is no queueing. Operand or ALU_FUNC changes during Busy have no effect.
- Between results, Arith_OUT and the flags hold their values.
- Arith_Flag is never high for two consecutive cycles from a single start.

Test Plan (W=16):
- Reset: assert RST for 2 cycles mid-divide, then release → all outputs 0, Busy=0, no Arith_Flag.
- ADD unsigned 0xFFFF+0x0001 → Arith_OUT=0x0001_0000, Carry_OUT=1, Arith_Flag pulse 1 cycle after start.
- ADD signed 0x7FFF+0x0001 → Arith_OUT=0x0000_8000, Ovf_OUT=1.
- SUB unsigned 3-5 → Carry_OUT=1, Arith_OUT=0x0001_FFFE.
- MUL: signed -3×7 → Arith_OUT=0xFFFF_FFEB. Back-to-back unsigned 0xFFFF×0xFFFF next cycle → 0xFFFE_0001, with two Arith_Flag pulses.
- DIV signed -7/2: Busy high for 17 cycles, Arith_Flag at cycle 18 → quotient 0xFFFD, remainder 0xFFFF. A start pulse during Busy is ignored.
- DIV 100/0 → Div_Zero=1, Arith_OUT=0x0064_FFFF, latency 1.
- DIV signed 0x8000/0xFFFF → quotient 0x8000, remainder 0, Ovf_OUT=1.
